// File: rtl/ecs3_pkg.sv
// ============================================================================
// Module : ecs3_pkg
// Brief  : Shared state enum, symbol size and symbol helpers for ECS3 stream.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ecs3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENC   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int SYM_MAX = 9;

    // Symbol length in bits: 5 for a raw nibble, else 3 + 3 per index field.
    function automatic logic [3:0] len(input logic flag, input logic [1:0] noi);
        if (flag) begin
            len = 4'd5;
        end else begin
            case (noi)
                2'd0:    len = 4'd3;
                2'd1:    len = 4'd6;
                default: len = 4'd9;
            endcase
        end
    endfunction

    // Left-justified symbol; unused low bits are zero so it can be OR-packed.
    function automatic logic [SYM_MAX-1:0] assemble(input logic       flag,
                                                    input logic [3:0] nib,
                                                    input logic [1:0] noi,
                                                    input logic [2:0] ind0,
                                                    input logic [2:0] ind1);
        if (flag) begin
            assemble = {1'b1, nib, 4'b0000};
        end else begin
            case (noi)
                2'd0:    assemble = {1'b0, noi, 6'b000000};
                2'd1:    assemble = {1'b0, noi, ind0, 3'b000};
                default: assemble = {1'b0, noi, ind0, ind1};
            endcase
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/ecs3_nibble_enc.sv
// ============================================================================
// Module : ecs3_nibble_enc
// Brief  : Combinational ECS3 nibble encoder (A,B,C,D -> Flag, NOI, Ind0, Ind1).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ecs3_nibble_enc (
    input  logic [3:0] nib,
    output logic       flag,
    output logic [1:0] noi,
    output logic [2:0] ind0,
    output logic [2:0] ind1
);

    logic [2:0] w_cnt;

    // Index fields hold bit position + 1 (A=4 .. D=1), scanning from A downward.
    always_comb begin
        w_cnt = 3'd0;
        ind0  = 3'd0;
        ind1  = 3'd0;
        for (int i = 3; i >= 0; i--) begin
            if (nib[i]) begin
                w_cnt = w_cnt + 3'd1;
                if (ind0 == 3'd0) begin
                    ind0 = 3'(i + 1);
                end else if (ind1 == 3'd0) begin
                    ind1 = 3'(i + 1);
                end
            end
        end
        flag = (w_cnt >= 3'd3);
        noi  = flag ? 2'd0 : w_cnt[1:0];
    end

endmodule

`default_nettype wire

// File: rtl/ecs3_stream_ctrl.sv
// ============================================================================
// Module : ecs3_stream_ctrl
// Brief  : Word-to-nibble ECS3 encoder front end with MSB-first symbol packer.
//          Optional statistics outputs enabled by ECS3_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ecs3_stream_ctrl
    import ecs3_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last
`ifdef ECS3_STATS_EN
    ,
    output logic [15:0]      stat_raw,
    output logic [31:0]      stat_bits
`endif
);

    localparam int ACC_W  = OUT_W + 8;
    localparam int FILL_W = $clog2(ACC_W + 1);
    localparam int NIBS   = IN_W / 4;
    localparam int NIB_W  = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_W);

    state_t             r_state,    w_state_nx;
    logic [ACC_W-1:0]   r_acc,      w_acc_nx;
    logic [FILL_W-1:0]  r_fill,     w_fill_nx;
    logic [IN_W-1:0]    r_word,     w_word_nx;
    logic [NIB_W-1:0]   r_nib,      w_nib_nx;
    logic               r_last,     w_last_nx;
    logic               r_out_valid, w_out_valid_nx;
    logic [OUT_W-1:0]   r_out_data,  w_out_data_nx;
    logic               r_out_last,  w_out_last_nx;

    logic               w_flag;
    logic [1:0]         w_noi;
    logic [2:0]         w_ind0, w_ind1;
    logic [3:0]         w_sym_len;
    logic [SYM_MAX-1:0] w_sym;
    logic [ACC_W-1:0]   w_placed, w_acc_d;
    logic [FILL_W-1:0]  w_fill_d;
    logic               w_free, w_drain, w_encode;

    ecs3_nibble_enc u_enc (
        .nib  (r_word[IN_W-1 -: 4]),
        .flag (w_flag),
        .noi  (w_noi),
        .ind0 (w_ind0),
        .ind1 (w_ind1)
    );

    assign w_sym_len = len(w_flag, w_noi);
    assign w_sym     = assemble(w_flag, r_word[IN_W-1 -: 4], w_noi, w_ind0, w_ind1);

    // Drain happens first; encode only sees the post-drain fill level.
    assign w_free   = !r_out_valid || out_ready;
    assign w_drain  = (r_fill >= OUT_W_F) && w_free;
    assign w_fill_d = w_drain ? (r_fill - OUT_W_F) : r_fill;
    assign w_acc_d  = w_drain ? (r_acc << OUT_W) : r_acc;
    assign w_encode = (r_state == ENC) && (w_fill_d < OUT_W_F);
    assign w_placed = {w_sym, {(ACC_W - SYM_MAX){1'b0}}} >> w_fill_d;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

    always_comb begin
        w_state_nx     = r_state;
        w_acc_nx       = w_acc_d;
        w_fill_nx      = w_fill_d;
        w_word_nx      = r_word;
        w_nib_nx       = r_nib;
        w_last_nx      = r_last;
        w_out_valid_nx = r_out_valid && !out_ready;
        w_out_data_nx  = r_out_data;
        w_out_last_nx  = r_out_last;

        if (w_drain) begin
            w_out_valid_nx = 1'b1;
            w_out_data_nx  = r_acc[ACC_W-1 -: OUT_W];
            w_out_last_nx  = 1'b0;
        end

        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_word_nx  = in_data;
                    w_last_nx  = in_last;
                    w_nib_nx   = NIB_W'(NIBS - 1);
                    w_state_nx = ENC;
                end
            end
            ENC: begin
                if (w_encode) begin
                    w_acc_nx  = w_acc_d | w_placed;
                    w_fill_nx = w_fill_d + FILL_W'(w_sym_len);
                    w_word_nx = r_word << 4;
                    w_nib_nx  = r_nib - NIB_W'(1);
                    if (r_nib == '0) begin
                        w_state_nx = r_last ? FLUSH : IDLE;
                    end
                end
            end
            FLUSH: begin
                if (w_drain) begin
                    if (w_fill_d == '0) begin
                        w_out_last_nx = 1'b1;
                        w_state_nx    = IDLE;
                    end
                end else if (r_fill == '0) begin
                    w_state_nx = IDLE;
                end else if ((r_fill < OUT_W_F) && w_free) begin
                    // Bits below the fill level are always zero, giving the padding.
                    w_out_valid_nx = 1'b1;
                    w_out_data_nx  = r_acc[ACC_W-1 -: OUT_W];
                    w_out_last_nx  = 1'b1;
                    w_acc_nx       = '0;
                    w_fill_nx      = '0;
                    w_state_nx     = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_fill      <= '0;
            r_word      <= '0;
            r_nib       <= '0;
            r_last      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_acc       <= w_acc_nx;
            r_fill      <= w_fill_nx;
            r_word      <= w_word_nx;
            r_nib       <= w_nib_nx;
            r_last      <= w_last_nx;
            r_out_valid <= w_out_valid_nx;
            r_out_data  <= w_out_data_nx;
            r_out_last  <= w_out_last_nx;
        end
    end

`ifdef ECS3_STATS_EN
    logic [15:0] r_stat_raw;
    logic [31:0] r_stat_bits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_raw  <= '0;
            r_stat_bits <= '0;
        end else if (w_encode) begin
            r_stat_raw  <= r_stat_raw + 16'(w_flag);
            r_stat_bits <= r_stat_bits + 32'(w_sym_len);
        end
    end

    assign stat_raw  = r_stat_raw;
    assign stat_bits = r_stat_bits;
`endif

endmodule

`default_nettype wire
